// File: rtl/miner_block_loader.sv
// AXI-Lite initiator: snapshot result, write 20-word block header, poll result until it changes; start->first AW ~3-4 cycles.
// Every channel waits on its ready/valid, one transaction at a time; MINER_LOADER_TIMEOUT_EN bounds polling to MAX_POLLS reads.
module miner_block_loader #(
    parameter logic [31:0] BLOCK_BASE  = 32'h0000_0504,
    parameter int          NUM_WORDS   = 20,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_0554,
    parameter int          POLL_GAP    = 16,
    parameter int          MAX_POLLS   = 65535
) (
    input  logic                      clk_main_a0,
    input  logic                      rst_main_n,
    input  logic                      start,
    input  logic [32*NUM_WORDS-1:0]   block,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [31:0]               nonce,
    output logic                      m_awvalid,
    output logic [31:0]               m_awaddr,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic                      m_arvalid,
    output logic [31:0]               m_araddr,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready
);

    localparam int                 BW       = 32 * NUM_WORDS;
    localparam int                 IDX_W    = $clog2(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [15:0]        GAP_LAST = 16'(POLL_GAP - 1);

    generate
        if (POLL_GAP < 1 || POLL_GAP > 65535 || NUM_WORDS < 2 || MAX_POLLS < 1 || MAX_POLLS > 65535) begin : g_bad_param
            $error("miner_block_loader: parameter out of range");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE, SNAP_AR, SNAP_R, WR, WR_B, GAP, POLL_AR, POLL_R, DONE
    } state_t;

    state_t           state, nxt;
    logic [BW-1:0]    block_q;
    logic [31:0]      wr_addr;
    logic [IDX_W-1:0] idx;
    logic [31:0]      snap_q;
    logic [31:0]      nonce_q;
    logic             err_q;
    logic             aw_done, w_done;
    logic [15:0]      gap_cnt;
    logic             aw_acc, w_acc, fin_err, fin_ok;

`ifdef MINER_LOADER_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        poll_hit;
    assign poll_hit = ({1'b0, poll_cnt} + 17'd1) == 17'(MAX_POLLS);
`endif

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) state <= IDLE;
        else             state <= nxt;
    end

    always_comb begin
        nxt     = state;
        fin_err = 1'b0;
        fin_ok  = 1'b0;
        aw_acc  = aw_done | m_awready;
        w_acc   = w_done | m_wready;
        case (state)
            IDLE:    if (start) nxt = SNAP_AR;
            SNAP_AR: if (m_arready) nxt = SNAP_R;
            SNAP_R: begin
                if (m_rvalid) begin
                    if (m_rresp != 2'b00) begin
                        nxt     = DONE;
                        fin_err = 1'b1;
                    end else begin
                        nxt = WR;
                    end
                end
            end
            WR:      if (aw_acc && w_acc) nxt = WR_B;
            WR_B: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        nxt     = DONE;
                        fin_err = 1'b1;
                    end else if (idx == LAST_IDX) begin
                        nxt = GAP;
                    end else begin
                        nxt = WR;
                    end
                end
            end
            GAP:     if (gap_cnt == GAP_LAST) nxt = POLL_AR;
            POLL_AR: if (m_arready) nxt = POLL_R;
            POLL_R: begin
                if (m_rvalid) begin
                    if (m_rresp != 2'b00) begin
                        nxt     = DONE;
                        fin_err = 1'b1;
                    end else if (m_rdata != snap_q) begin
                        nxt    = DONE;
                        fin_ok = 1'b1;
                    end else begin
`ifdef MINER_LOADER_TIMEOUT_EN
                        if (poll_hit) begin
                            nxt     = DONE;
                            fin_err = 1'b1;
                        end else begin
                            nxt = GAP;
                        end
`else
                        nxt = GAP;
`endif
                    end
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The header is shifted out MSB-word first, so the beat is always the top word.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            block_q <= '0;
            wr_addr <= '0;
            idx     <= '0;
            snap_q  <= '0;
            nonce_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                block_q <= block;
                wr_addr <= BLOCK_BASE;
                idx     <= '0;
            end
            if (state == SNAP_R && m_rvalid) snap_q <= m_rdata;
            aw_done <= (state == WR && nxt == WR) ? aw_acc : 1'b0;
            w_done  <= (state == WR && nxt == WR) ? w_acc  : 1'b0;
            if (state == WR_B && m_bvalid && m_bresp == 2'b00) begin
                idx     <= idx + 1'b1;
                wr_addr <= wr_addr + 32'd4;
                block_q <= {block_q[BW-33:0], 32'h0};
            end
            if (nxt == GAP && state != GAP)                 gap_cnt <= '0;
            else if (state == GAP && gap_cnt != 16'hFFFF)   gap_cnt <= gap_cnt + 16'd1;
            if (fin_ok)      nonce_q <= m_rdata;
            if (nxt == DONE) err_q   <= fin_err;
        end
    end

`ifdef MINER_LOADER_TIMEOUT_EN
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n)                 poll_cnt <= '0;
        else if (state == IDLE && start) poll_cnt <= '0;
        else if (state == POLL_R && m_rvalid && m_rresp == 2'b00 && m_rdata == snap_q)
            poll_cnt <= poll_cnt + 16'd1;
    end
`endif

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && err_q;
    assign nonce     = nonce_q;
    assign m_awvalid = (state == WR) && !aw_done;
    assign m_wvalid  = (state == WR) && !w_done;
    assign m_awaddr  = (state == WR) ? wr_addr : '0;
    assign m_wdata   = (state == WR) ? block_q[BW-1 -: 32] : '0;
    assign m_wstrb   = (state == WR) ? 4'hF : 4'h0;
    assign m_bready  = (state == WR_B);
    assign m_arvalid = (state == SNAP_AR) || (state == POLL_AR);
    assign m_araddr  = m_arvalid ? RESULT_ADDR : '0;
    assign m_rready  = (state == SNAP_R) || (state == POLL_R);

endmodule

// File: tb/tb_miner_block_loader.sv
// Bench for miner_block_loader: AXI-Lite slave model, table vectors, reset corner and randomized transactions.
module tb_miner_block_loader;

    localparam int PG = 16;
`ifdef MINER_LOADER_TIMEOUT_EN
    localparam int MP = 4;
`else
    localparam int MP = 65535;
`endif
    localparam logic [31:0] BASE = 32'h0000_0504;
    localparam logic [31:0] RES  = 32'h0000_0554;

    logic         clk_main_a0 = 1'b0;
    logic         rst_main_n;
    logic         start;
    logic [639:0] block;
    logic         busy, done, err;
    logic [31:0]  nonce;
    logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic         m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]   m_wstrb;
    logic [1:0]   m_bresp, m_rresp;

    miner_block_loader #(.POLL_GAP(PG), .MAX_POLLS(MP)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n), .start(start), .block(block),
        .busy(busy), .done(done), .err(err), .nonce(nonce),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Slave model state shared with the test sequence
    int          cfg_wdly, cfg_bdly, cfg_errw, cfg_rerr;
    logic [31:0] rd_vals[$];
    logic [31:0] wr_a[$], wr_d[$];
    int          ar_cyc[$];
    int          n_aw, n_w, n_b, n_rd, viol, cyc;
    bit          slave_clr = 1'b0;

    initial begin
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, b_wait, rd_pend;
        logic [31:0] cap_a, cap_d, la, ld;
        int wcnt, bcnt;
        {hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, b_wait, rd_pend} = '0;
        wcnt = 0; bcnt = 0; cap_a = 0; cap_d = 0; la = 0; ld = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(negedge clk_main_a0);
            cyc++;
            if (slave_clr) begin
                {hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, b_wait, rd_pend} = '0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                wr_a.delete(); wr_d.delete(); ar_cyc.delete();
                n_aw = 0; n_w = 0; n_b = 0; n_rd = 0; viol = 0;
                slave_clr = 1'b0;
                continue;
            end
            if (hs_aw) begin aw_got = 1; la = cap_a; n_aw++; wcnt = 0; end
            if (hs_w)  begin w_got = 1; ld = cap_d; n_w++; end
            if (hs_b)  begin m_bvalid = 0; n_b++; end
            if (hs_ar) begin rd_pend = 1; ar_cyc.push_back(cyc); end
            if (hs_r)  m_rvalid = 0;
            if (aw_got && !w_got && (m_awvalid || !m_wvalid)) viol++;
            if ((m_arvalid || m_rready) && (m_awvalid || m_wvalid || m_bready)) viol++;
            if (aw_got && w_got) begin
                wr_a.push_back(la); wr_d.push_back(ld);
                aw_got = 0; w_got = 0; b_wait = 1; bcnt = 0;
            end
            m_awready = 1;
            if (cfg_wdly == 0) m_wready = 1;
            else begin
                m_wready = aw_got && (wcnt >= cfg_wdly);
                if (aw_got) wcnt++;
            end
            if (b_wait) begin
                if (bcnt >= cfg_bdly) begin
                    m_bvalid = 1;
                    m_bresp  = (wr_a.size() - 1 == cfg_errw) ? 2'b10 : 2'b00;
                    b_wait   = 0;
                end else bcnt++;
            end
            m_arready = 1;
            if (rd_pend) begin
                m_rvalid = 1;
                m_rdata  = (rd_vals.size() == 0) ? 32'h0 :
                           rd_vals[(n_rd < rd_vals.size()) ? n_rd : rd_vals.size() - 1];
                m_rresp  = (n_rd == cfg_rerr) ? 2'b10 : 2'b00;
                if (m_araddr != RES && m_araddr != 0) viol++;
                n_rd++;
                rd_pend = 0;
            end
            hs_aw = m_awvalid && m_awready; cap_a = m_awaddr;
            hs_w  = m_wvalid && m_wready;   cap_d = m_wdata;
            if (hs_w && m_wstrb != 4'hF) viol++;
            if (m_arvalid && m_araddr != RES) viol++;
            hs_b  = m_bready && m_bvalid;
            hs_ar = m_arvalid && m_arready;
            hs_r  = m_rready && m_rvalid;
        end
    end

    typedef struct {
        bit          rnd_blk;
        logic [31:0] snap;
        int          npolls;
        logic [31:0] newres;
        int          wdly, bdly, errw, rerr;
        bit          bstart;
        bit          exp_err;
        logic [31:0] exp_nonce;
        int          exp_w, exp_r;
    } vec_t;

    function automatic logic [31:0] word_of(input logic [639:0] b, input int i);
        logic [639:0] t;
        t = b >> (32 * (19 - i));
        return t[31:0];
    endfunction

    function automatic logic [639:0] make_blk(input bit rnd);
        logic [639:0] b;
        for (int k = 0; k < 20; k++) b[32*k +: 32] = rnd ? 32'($urandom()) : 32'(19 - k);
        return b;
    endfunction

    task automatic prep(input vec_t v);
        cfg_wdly = v.wdly; cfg_bdly = v.bdly; cfg_errw = v.errw; cfg_rerr = v.rerr;
        wr_a.delete(); wr_d.delete(); ar_cyc.delete();
        n_aw = 0; n_w = 0; n_b = 0; n_rd = 0; viol = 0;
        rd_vals.delete();
        rd_vals.push_back(v.snap);
        for (int k = 1; k <= v.npolls; k++) rd_vals.push_back((k == v.npolls) ? v.newres : v.snap);
    endtask

    task automatic run_txn(input string tag, input logic [639:0] blk, input vec_t v);
        bit got;
        int min_gap;
        prep(v);
        @(negedge clk_main_a0); start = 1; block = blk;
        @(negedge clk_main_a0); start = 0;
        if (v.bstart) begin
            repeat (8) @(negedge clk_main_a0);
            check({tag, ".busy_mid"}, 64'(busy), 64'd1);
            start = 1; block = ~blk;
            @(negedge clk_main_a0); start = 0;
        end
        got = 0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk_main_a0);
            if (done) begin got = 1; break; end
        end
        check({tag, ".done_seen"}, 64'(got), 64'd1);
        check({tag, ".err"}, 64'(err), 64'(v.exp_err));
        check({tag, ".nonce"}, 64'(nonce), 64'(v.exp_nonce));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk_main_a0);
        check({tag, ".done_width"}, 64'(done), 64'd0);
        repeat (10) @(negedge clk_main_a0);
        check({tag, ".idle_after"}, 64'({busy, done}), 64'd0);
        check({tag, ".n_aw"}, 64'(n_aw), 64'(v.exp_w));
        check({tag, ".n_w"}, 64'(n_w), 64'(v.exp_w));
        check({tag, ".n_b"}, 64'(n_b), 64'(v.exp_w));
        check({tag, ".n_rd"}, 64'(n_rd), 64'(v.exp_r));
        check({tag, ".protocol"}, 64'(viol), 64'd0);
        for (int i = 0; i < wr_a.size() && i < v.exp_w; i++) begin
            check($sformatf("%s.awaddr[%0d]", tag, i), 64'(wr_a[i]), 64'(BASE + 32'(4 * i)));
            check($sformatf("%s.wdata[%0d]", tag, i), 64'(wr_d[i]), 64'(word_of(blk, i)));
        end
        if (ar_cyc.size() >= 3) begin
            min_gap = 1 << 30;
            for (int i = 2; i < ar_cyc.size(); i++)
                if (ar_cyc[i] - ar_cyc[i-1] < min_gap) min_gap = ar_cyc[i] - ar_cyc[i-1];
            check({tag, ".poll_gap_ok"}, 64'(min_gap >= PG + 1), 64'd1);
        end
    endtask

    vec_t        tbl[6];
    vec_t        v;
    logic [31:0] m_nonce;
    logic [639:0] blk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 32'h0,  3, 32'h1234ABCD, 0, 0, -1, -1, 1'b0, 1'b0, 32'h1234ABCD, 20, 4};
        tbl[1] = '{1'b1, 32'h10, 1, 32'h99,       2, 3, -1, -1, 1'b0, 1'b0, 32'h99,       20, 2};
        tbl[2] = '{1'b1, 32'h10, 1, 32'h77,       0, 0,  7, -1, 1'b0, 1'b1, 32'h99,        8, 1};
        tbl[3] = '{1'b0, 32'h55, 6, 32'h56,       0, 0, -1, -1, 1'b1, 1'b0, 32'h56,       20, 7};
        tbl[4] = '{1'b1, 32'h3,  2, 32'h4,        1, 0, -1,  0, 1'b0, 1'b1, 32'h56,        0, 1};
        tbl[5] = '{1'b1, 32'h7,  5, 32'h8,        0, 2, -1,  2, 1'b0, 1'b1, 32'h56,       20, 3};

        rst_main_n = 0; start = 0; block = '0;
        cfg_wdly = 0; cfg_bdly = 0; cfg_errw = -1; cfg_rerr = -1;
        repeat (3) @(negedge clk_main_a0);
        check("reset.ctrl", 64'({busy, done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
        check("reset.nonce", 64'(nonce), 64'd0);
        check("reset.addr", 64'({m_awaddr, m_araddr}), 64'd0);
        rst_main_n = 1;
        repeat (2) @(negedge clk_main_a0);
        check("post_reset.busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), make_blk(tbl[i].rnd_blk), tbl[i]);

        // Asynchronous reset while a write beat is on the bus
        v = tbl[1];
        prep(v);
        blk = make_blk(1'b1);
        @(negedge clk_main_a0); start = 1; block = blk;
        @(negedge clk_main_a0); start = 0;
        for (int t = 0; t < 50 && !m_awvalid; t++) @(negedge clk_main_a0);
        check("rst_mid.in_wr", 64'(m_awvalid), 64'd1);
        #2 rst_main_n = 0;
        #1;
        check("rst_mid.ctrl", 64'({busy, done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
        check("rst_mid.data", 64'({m_awaddr, m_wdata}), 64'd0);
        check("rst_mid.nonce", 64'(nonce), 64'd0);
        slave_clr = 1'b1;
        repeat (3) @(negedge clk_main_a0);
        rst_main_n = 1;
        @(negedge clk_main_a0);
        m_nonce = 32'h0;
        v = '{1'b0, 32'hA, 2, 32'hB, 0, 1, -1, -1, 1'b0, 1'b0, 32'hB, 20, 3};
        run_txn("after_rst", make_blk(1'b0), v);
        m_nonce = 32'hB;

        // Randomized transactions against a sequence-level model
        for (int r = 0; r < 6; r++) begin
            logic [31:0] seq[$];
            v.rnd_blk = 1'b1;
            v.snap    = $urandom();
            v.npolls  = $urandom_range(1, 4);
            v.newres  = v.snap ^ ($urandom() | 32'h1);
            v.wdly    = $urandom_range(0, 3);
            v.bdly    = $urandom_range(0, 3);
            v.errw    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : -1;
            v.rerr    = -1;
            v.bstart  = 1'b0;
            seq.delete();
            for (int k = 1; k <= v.npolls; k++) seq.push_back((k == v.npolls) ? v.newres : v.snap);
            if (v.errw >= 0) begin
                v.exp_err = 1'b1; v.exp_w = v.errw + 1; v.exp_r = 1; v.exp_nonce = m_nonce;
            end else begin
                v.exp_err = 1'b0; v.exp_w = 20; v.exp_nonce = m_nonce; v.exp_r = 1;
                foreach (seq[k]) begin
                    v.exp_r++;
                    if (seq[k] != v.snap) begin v.exp_nonce = seq[k]; break; end
                end
            end
            m_nonce = v.exp_nonce;
            run_txn($sformatf("rnd%0d", r), make_blk(1'b1), v);
        end

`ifdef MINER_LOADER_TIMEOUT_EN
        v = '{1'b0, 32'h42, 10, 32'h42, 0, 0, -1, -1, 1'b0, 1'b1, m_nonce, 20, 1 + MP};
        run_txn("timeout", make_blk(1'b0), v);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
